// File: rtl/uart_rx_pkt_ctrl_if.sv
// Byte-stream, packet-handover and error-pulse signals between uart_rx,
// the packet controller and the command logic.
interface uart_rx_pkt_ctrl_if #(
    parameter int MAX_LEN = 16
) ();
    localparam int AW = $clog2(MAX_LEN);

    logic [7:0]    rx_data;
    logic          rx_available;
    logic          rx_idle;
    logic          pkt_ready;
    logic [AW-1:0] rd_addr;
    logic [7:0]    rd_data;
    logic          pkt_valid;
    logic [7:0]    pkt_len;
    logic          err_len;
    logic          err_chk;
    logic          err_timeout;
    logic          err_overrun;

    // Packet controller side
    modport slave (
        input  rx_data, rx_available, rx_idle, pkt_ready, rd_addr,
        output rd_data, pkt_valid, pkt_len,
        output err_len, err_chk, err_timeout, err_overrun
    );

    // Byte source / packet consumer side
    modport master (
        output rx_data, rx_available, rx_idle, pkt_ready, rd_addr,
        input  rd_data, pkt_valid, pkt_len,
        input  err_len, err_chk, err_timeout, err_overrun
    );
endinterface

// File: rtl/uart_rx_pkt_ctrl.sv
// Frames the uart_rx byte stream into SYNC/LEN/payload/CHK packets, buffers the
// payload and holds a checksum-good packet until the consumer releases it.
module uart_rx_pkt_ctrl #(
    parameter int         MAX_LEN   = 16,
    parameter logic [7:0] SYNC_BYTE = 8'hA5
) (
    input  logic                  clk,
    input  logic                  reset,
    uart_rx_pkt_ctrl_if.slave     bus
);
    localparam int         AW        = $clog2(MAX_LEN);
    localparam logic [7:0] MAX_LEN_B = 8'(MAX_LEN);

    typedef enum logic [2:0] {
        ST_HUNT = 3'd0,
        ST_LEN  = 3'd1,
        ST_PAY  = 3'd2,
        ST_CHK  = 3'd3,
        ST_HOLD = 3'd4
    } state_t;

    state_t     state_q, state_d;
    logic [7:0] len_q, len_d;
    logic [7:0] sum_q, sum_d;
    logic [7:0] cnt_q, cnt_d;
    logic [7:0] pkt_len_q, pkt_len_d;
    logic [7:0] rd_data_q, rd_data_d;
    logic       pkt_valid_q, pkt_valid_d;
    logic       err_len_q, err_len_d;
    logic       err_chk_q, err_chk_d;
    logic       err_timeout_q, err_timeout_d;
    logic       err_overrun_q, err_overrun_d;
    logic       buf_we_s;
    logic       len_bad_s;
    logic [7:0] buf_mem [2**AW];

    assign len_bad_s = (bus.rx_data == 8'd0) || (bus.rx_data > MAX_LEN_B);

    // State and control registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= ST_HUNT;
            len_q         <= 8'd0;
            sum_q         <= 8'd0;
            cnt_q         <= 8'd0;
            pkt_len_q     <= 8'd0;
            rd_data_q     <= 8'd0;
            pkt_valid_q   <= 1'b0;
            err_len_q     <= 1'b0;
            err_chk_q     <= 1'b0;
            err_timeout_q <= 1'b0;
            err_overrun_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            len_q         <= len_d;
            sum_q         <= sum_d;
            cnt_q         <= cnt_d;
            pkt_len_q     <= pkt_len_d;
            rd_data_q     <= rd_data_d;
            pkt_valid_q   <= pkt_valid_d;
            err_len_q     <= err_len_d;
            err_chk_q     <= err_chk_d;
            err_timeout_q <= err_timeout_d;
            err_overrun_q <= err_overrun_d;
        end
    end

    // Payload buffer: unreset storage, written only while collecting payload
    always_ff @(posedge clk) begin
        if (buf_we_s) begin
            buf_mem[cnt_q[AW-1:0]] <= bus.rx_data;
        end
    end

    // Next-state: a received byte always wins over a same-cycle idle timeout
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_HUNT: begin
                if (bus.rx_available && (bus.rx_data == SYNC_BYTE)) state_d = ST_LEN;
                else                                                state_d = ST_HUNT;
            end
            ST_LEN: begin
                if (bus.rx_available) state_d = len_bad_s ? ST_HUNT : ST_PAY;
                else if (bus.rx_idle) state_d = ST_HUNT;
                else                  state_d = ST_LEN;
            end
            ST_PAY: begin
                if (bus.rx_available) state_d = (cnt_q == len_q - 8'd1) ? ST_CHK : ST_PAY;
                else if (bus.rx_idle) state_d = ST_HUNT;
                else                  state_d = ST_PAY;
            end
            ST_CHK: begin
                if (bus.rx_available) state_d = (bus.rx_data == sum_q) ? ST_HOLD : ST_HUNT;
                else if (bus.rx_idle) state_d = ST_HUNT;
                else                  state_d = ST_CHK;
            end
            ST_HOLD: begin
                if (bus.pkt_ready) state_d = ST_HUNT;
                else               state_d = ST_HOLD;
            end
            default: state_d = ST_HUNT;
        endcase
    end

    // Datapath and registered-output next values
    always_comb begin
        len_d         = len_q;
        sum_d         = sum_q;
        cnt_d         = cnt_q;
        pkt_len_d     = pkt_len_q;
        buf_we_s      = 1'b0;
        err_len_d     = 1'b0;
        err_chk_d     = 1'b0;
        err_timeout_d = 1'b0;
        err_overrun_d = 1'b0;
        pkt_valid_d   = (state_d == ST_HOLD);
        rd_data_d     = buf_mem[bus.rd_addr];
        case (state_q)
            ST_LEN: begin
                if (bus.rx_available) begin
                    if (len_bad_s) begin
                        err_len_d = 1'b1;
                    end else begin
                        len_d = bus.rx_data;
                        sum_d = bus.rx_data;
                        cnt_d = 8'd0;
                    end
                end else begin
                    err_timeout_d = bus.rx_idle;
                end
            end
            ST_PAY: begin
                if (bus.rx_available) begin
                    buf_we_s = 1'b1;
                    sum_d    = sum_q + bus.rx_data;
                    cnt_d    = cnt_q + 8'd1;
                end else begin
                    err_timeout_d = bus.rx_idle;
                end
            end
            ST_CHK: begin
                if (bus.rx_available) begin
                    if (bus.rx_data == sum_q) pkt_len_d = len_q;
                    else                      err_chk_d = 1'b1;
                end else begin
                    err_timeout_d = bus.rx_idle;
                end
            end
            ST_HOLD: err_overrun_d = bus.rx_available;
            default: err_overrun_d = 1'b0;
        endcase
    end

    assign bus.rd_data     = rd_data_q;
    assign bus.pkt_valid   = pkt_valid_q;
    assign bus.pkt_len     = pkt_len_q;
    assign bus.err_len     = err_len_q;
    assign bus.err_chk     = err_chk_q;
    assign bus.err_timeout = err_timeout_q;
    assign bus.err_overrun = err_overrun_q;
endmodule
